// File: rtl/audio_voice_synth.sv
// audio_voice_synth: time-multiplexed multi-voice oscillator mixer with sigma-delta PDM output; SYNTH_NOISE_EN adds the LFSR noise source
module audio_voice_synth #(
    parameter int VOICES   = 4,
    parameter int PHASE_W  = 16,
    parameter int SAMPLE_W = 12,
    localparam int VSEL_W  = (VOICES > 1) ? $clog2(VOICES) : 1,
    localparam int MIX_W   = SAMPLE_W + $clog2(VOICES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_tick,
    input  logic               cfg_we,
    input  logic [VSEL_W-1:0]  cfg_voice,
    input  logic [PHASE_W-1:0] cfg_freq,
    input  logic [1:0]         cfg_wave,
    input  logic [3:0]         cfg_vol,
    output logic               busy,
    output logic               sample_valid,
    output logic [MIX_W-1:0]   mix,
    output logic               pdm_out
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic [VSEL_W-1:0] vidx_q, vidx_d;
    logic [MIX_W-1:0] acc_q, acc_d, mix_q, mix_d, pdm_acc_q, pdm_acc_d;
    logic valid_q, valid_d, pdm_q, pdm_d;
    logic [PHASE_W-1:0] phase_q [VOICES];
    logic [PHASE_W-1:0] phase_d [VOICES];
    logic [PHASE_W-1:0] freq_q [VOICES];
    logic [PHASE_W-1:0] freq_d [VOICES];
    logic [1:0] wave_q [VOICES];
    logic [1:0] wave_d [VOICES];
    logic [3:0] vol_q [VOICES];
    logic [3:0] vol_d [VOICES];
    logic [PHASE_W-1:0] p;
    logic [SAMPLE_W-1:0] tri_w, noise_w, wv;
    logic [SAMPLE_W+3:0] prod;
`ifdef SYNTH_NOISE_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [SAMPLE_W-1:0] noise_hold_q [VOICES];
    logic [SAMPLE_W-1:0] noise_hold_d [VOICES];
    logic wrap;
`endif
    always_comb begin
        state_d = state_q;
        vidx_d  = vidx_q;
        acc_d   = acc_q;
        mix_d   = mix_q;
        valid_d = 1'b0;
        phase_d = phase_q;
        freq_d  = freq_q;
        wave_d  = wave_q;
        vol_d   = vol_q;
        p       = phase_q[vidx_q] + freq_q[vidx_q];
        tri_w   = p[PHASE_W-2 -: SAMPLE_W] ^ {SAMPLE_W{p[PHASE_W-1]}};
`ifdef SYNTH_NOISE_EN
        lfsr_d       = lfsr_q;
        noise_hold_d = noise_hold_q;
        wrap         = p < phase_q[vidx_q];
        noise_w      = wrap ? lfsr_q[15 -: SAMPLE_W] : noise_hold_q[vidx_q];
`else
        noise_w = '0;
`endif
        wv = (wave_q[vidx_q] == 2'd0) ? p[PHASE_W-1 -: SAMPLE_W] :
             (wave_q[vidx_q] == 2'd1) ? {SAMPLE_W{~p[PHASE_W-1]}} :
             (wave_q[vidx_q] == 2'd2) ? tri_w : noise_w;
        prod = {4'd0, wv} * {{SAMPLE_W{1'b0}}, vol_q[vidx_q]};
        if (cfg_we) begin
            freq_d[cfg_voice] = cfg_freq;
            wave_d[cfg_voice] = cfg_wave;
            vol_d[cfg_voice]  = cfg_vol;
        end
        if (state_q == IDLE) begin
            if (sample_tick) begin
                state_d = RUN;
                vidx_d  = '0;
                acc_d   = '0;
            end
        end else begin
            phase_d[vidx_q] = p;
            acc_d  = acc_q + MIX_W'(prod >> 4);
            vidx_d = vidx_q + 1'b1;
`ifdef SYNTH_NOISE_EN
            if (wrap) begin
                noise_hold_d[vidx_q] = lfsr_q[15 -: SAMPLE_W];
                lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
            end
`endif
            if (vidx_q == VSEL_W'(VOICES - 1)) begin
                state_d = IDLE;
                mix_d   = acc_d;
                valid_d = 1'b1;
            end
        end
        {pdm_d, pdm_acc_d} = {1'b0, pdm_acc_q} + {1'b0, mix_q};
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vidx_q    <= '0;
            acc_q     <= '0;
            mix_q     <= '0;
            valid_q   <= 1'b0;
            pdm_acc_q <= '0;
            pdm_q     <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                phase_q[i] <= '0;
                freq_q[i]  <= '0;
                wave_q[i]  <= '0;
                vol_q[i]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            vidx_q    <= vidx_d;
            acc_q     <= acc_d;
            mix_q     <= mix_d;
            valid_q   <= valid_d;
            pdm_acc_q <= pdm_acc_d;
            pdm_q     <= pdm_d;
            phase_q   <= phase_d;
            freq_q    <= freq_d;
            wave_q    <= wave_d;
            vol_q     <= vol_d;
        end
    end
`ifdef SYNTH_NOISE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
            for (int i = 0; i < VOICES; i++) noise_hold_q[i] <= '0;
        end else begin
            lfsr_q       <= lfsr_d;
            noise_hold_q <= noise_hold_d;
        end
    end
`endif
    assign busy         = (state_q == RUN);
    assign sample_valid = valid_q;
    assign mix          = mix_q;
    assign pdm_out      = pdm_q;
endmodule

// File: tb/tb_audio_voice_synth.sv
// tb_audio_voice_synth: scoreboard bench with a behavioural synth model for audio_voice_synth
module tb_audio_voice_synth;
    localparam int V = 4, PW = 16, SW = 12, VW = 2, MW = 14;
`ifdef SYNTH_NOISE_EN
    localparam bit NOISE = 1'b1;
`else
    localparam bit NOISE = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, sample_tick = 1'b0, cfg_we = 1'b0;
    logic [VW-1:0] cfg_voice = '0;
    logic [PW-1:0] cfg_freq = '0;
    logic [1:0] cfg_wave = '0;
    logic [3:0] cfg_vol = '0;
    logic busy, sample_valid, pdm_out;
    logic [MW-1:0] mix;

    audio_voice_synth #(.VOICES(V), .PHASE_W(PW), .SAMPLE_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .cfg_we(cfg_we),
        .cfg_voice(cfg_voice), .cfg_freq(cfg_freq), .cfg_wave(cfg_wave), .cfg_vol(cfg_vol),
        .busy(busy), .sample_valid(sample_valid), .mix(mix), .pdm_out(pdm_out)
    );

    always #5 clk = ~clk;

    typedef struct {int edge_n; int val;} exp_t;
    int total = 0, bad = 0, cyc = 0;
    int m_phase[V], m_freq[V], m_wave[V], m_vol[V], m_hold[V];
    int m_lfsr = 'hACE1, last_acc = -100;
    exp_t exp_q[$];
    exp_t pend_q[$];
    int ref_mix = 0, pdm_acc = 0, ones_dut = 0, ones_ref = 0;
    bit pdm_exp = 1'b0;

    function automatic void check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void model_reset();
        for (int v = 0; v < V; v++) begin
            m_phase[v] = 0; m_freq[v] = 0; m_wave[v] = 0; m_vol[v] = 0; m_hold[v] = 0;
        end
        m_lfsr = 'hACE1;
        last_acc = -100;
        ref_mix = 0;
        exp_q.delete();
        pend_q.delete();
    endfunction

    // One full sample: every voice advances, produces its waveform value, and is scaled by volume.
    function automatic int model_sample();
        int acc = 0;
        for (int v = 0; v < V; v++) begin
            int np, w;
            bit wrapped;
            np = m_phase[v] + m_freq[v];
            wrapped = np >= 65536;
            np = np % 65536;
            m_phase[v] = np;
            if (NOISE && wrapped) begin
                m_hold[v] = m_lfsr >> 4;
                m_lfsr = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 'hB400) : (m_lfsr >> 1);
            end
            case (m_wave[v])
                0: w = np / 16;
                1: w = (np < 32768) ? 4095 : 0;
                2: w = (np >= 32768) ? 4095 - (np - 32768) / 8 : np / 8;
                default: w = NOISE ? m_hold[v] : 0;
            endcase
            acc += (w * m_vol[v]) / 16;
        end
        return acc;
    endfunction

    task automatic drive(bit tick, bit we, int voice, int freq, int wave, int vol);
        int e;
        exp_t x;
        e = cyc + 1;
        sample_tick = tick; cfg_we = we;
        cfg_voice = VW'(voice); cfg_freq = PW'(freq); cfg_wave = 2'(wave); cfg_vol = 4'(vol);
        if (we) begin
            m_freq[voice] = freq; m_wave[voice] = wave; m_vol[voice] = vol;
        end
        if (tick && e >= last_acc + V + 1) begin
            x.edge_n = e + V;
            x.val = model_sample();
            exp_q.push_back(x);
            pend_q.push_back(x);
            last_acc = e;
        end
    endtask

    task automatic step(bit tick, bit we, int voice, int freq, int wave, int vol);
        @(negedge clk);
        drive(tick, we, voice, freq, wave, vol);
    endtask

    task automatic idle(int n);
        repeat (n) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(int n);
        @(negedge clk);
        rst_n = 1'b0; sample_tick = 1'b0; cfg_we = 1'b0;
        model_reset();
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // PDM reference and output monitor
    always @(posedge clk) begin
        exp_t x;
        cyc++;
        if (!rst_n) begin
            pdm_acc = 0; pdm_exp = 1'b0; ref_mix = 0;
        end else begin
            pdm_acc += ref_mix;
            pdm_exp = pdm_acc >= 16384;
            pdm_acc = pdm_acc % 16384;
            if (pend_q.size() > 0 && pend_q[0].edge_n == cyc) begin
                x = pend_q.pop_front();
                ref_mix = x.val;
            end
        end
        #1;
        ones_dut += int'(pdm_out);
        ones_ref += int'(pdm_exp);
        check("busy", int'(busy), int'(cyc >= last_acc && cyc < last_acc + V));
        if (sample_valid) begin
            if (exp_q.size() == 0) check("spurious_valid", 1, 0);
            else begin
                x = exp_q.pop_front();
                check("valid_cycle", cyc, x.edge_n);
                check("mix", int'(mix), x.val);
                check("pdm_ones", ones_dut, ones_ref);
            end
        end else if (exp_q.size() > 0 && exp_q[0].edge_n <= cyc) begin
            x = exp_q.pop_front();
            check("missing_valid", 0, 1);
        end
    end

    initial begin
        int z, nv, nd, e, v;
        int tri_exp[3] = '{'h7FF, 0, 'h7FF};
        int vals[8];
        bit tk, we, seen;
        model_reset();
        do_reset(4);
        z = 0;
        repeat (100) begin
            idle(1);
            z += int'(pdm_out);
        end
        check("reset_pdm_ones", z, 0);
        check("reset_mix", int'(mix), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(sample_valid), 0);

        step(0, 1, 0, 'h1000, 0, 15);
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 0, 0, 0, 0);
            idle(15);
            check("saw_mix", int'(mix), 'h0F0 * (k + 1));
        end

        for (int i = 0; i < V; i++) step(0, 1, i, 0, 1, 15);
        step(1, 0, 0, 0, 0, 0);
        idle(8);
        check("square_mix", int'(mix), 'h3BFC);
        z = 0;
        repeat (16384) begin
            idle(1);
            z += int'(pdm_out);
        end
        check("square_pdm_ones", z, 15356);

        do_reset(2);
        step(0, 1, 0, 'h8000, 2, 8);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 0, 0, 0);
            idle(7);
            check("tri_mix", int'(mix), tri_exp[k]);
        end

        step(0, 1, 0, 'h8000, 2, 0);
        step(0, 1, 2, 0, 1, 15);
        step(1, 0, 0, 0, 0, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 0);
        nv = 0;
        repeat (12) begin
            idle(1);
            nv += int'(sample_valid);
        end
        check("drop_valid_count", nv, 1);
        step(1, 0, 0, 0, 0, 0);
        idle(2);
        step(0, 1, 2, 0, 1, 0);
        idle(6);
        check("collision_old_vol", int'(mix), 'hEFF);
        step(1, 0, 0, 0, 0, 0);
        idle(7);
        check("collision_new_vol", int'(mix), 0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            e = cyc + 1;
            tk = ($urandom_range(3) == 0);
            we = ($urandom_range(3) == 0);
            v = $urandom_range(V - 1);
            if (e > last_acc && e <= last_acc + V && v > e - last_acc - 1) we = 1'b0;
            drive(tk, we, v, $urandom_range(16'hFFFF), $urandom_range(3), $urandom_range(15));
        end
        idle(10);

        do_reset(2);
        step(0, 1, 0, 'h4000, 3, 15);
        for (int k = 0; k < 8; k++) begin
            step(1, 0, 0, 0, 0, 0);
            idle(7);
            vals[k] = int'(mix);
        end
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            seen = 1'b0;
            for (int j = 0; j < i; j++) if (vals[j] == vals[i]) seen = 1'b1;
            if (vals[i] != 0 && !seen) nd++;
        end
`ifdef SYNTH_NOISE_EN
        check("noise_distinct_ge2", int'(nd >= 2), 1);
`else
        check("noise_distinct_none", nd, 0);
`endif
        step(1, 0, 0, 0, 0, 0);
        idle(1);
        @(negedge clk);
        rst_n = 1'b0; sample_tick = 1'b0; cfg_we = 1'b0;
        model_reset();
        @(negedge clk);
        check("midrun_mix", int'(mix), 0);
        check("midrun_busy", int'(busy), 0);
        check("midrun_valid", int'(sample_valid), 0);
        check("midrun_pdm", int'(pdm_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        check("queue_drained", exp_q.size(), 0);
        check("final_pdm_ones", ones_dut, ones_ref);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
